fetch_tag_check: RTL and testbench

FETCH_TAG_CHECK -- requirements
Module: fetch_tag_check

---
 rtl/fetch_tag_check.sv | 213 +++++++++++++++++++++
 tb/tb_fetch_tag_check.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_tag_check.sv
// -----------------------------------------------------------------------------
// fetch_tag_check
//
// Purpose:
//   Fetch-stage tag compare and miss handling. It compares the tag-memory read
//   result against the requested tag. A hit is registered to the
//   instruction-read stage. A miss is captured, and the block then runs a
//   line-fill handshake (REQ -> WAIT_FILL). It writes the new tag (UPDATE) and
//   replays the missed fetch as a hit (REPLAY). While a miss is in flight,
//   stall_o holds off new tag queries.
//
// Optional feature:
//   FETCH_TAG_CHECK_PERF_CNT_EN - when defined, adds 32-bit hit and miss
//   performance counters (hitCount_o, missCount_o).
//
// Ports:
//   clock_i           rising-edge clock
//   reset_i           asynchronous active-low reset
//   flushPipeline_i   pipeline flush
//   fetchUnitStall_i  downstream stall; holds hit_o/index_o/offset_o
//   enable_i          tag-query result valid
//   tag_i             requested tag
//   queriedTag_i      stored entry {tag, valid}
//   index_i/offset_i  set index / byte offset of the query
//   hit_o/index_o/offset_o  registered hit to the instruction-read stage
//   stall_o           busy with a miss; blocks upstream queries
//   missReq_o/missAddr_o    line-fill request and line address
//   missAck_i         fill request accepted
//   fillDone_i        line data written
//   newTag_o/newIndex_o/updateEnable_o  one-cycle tag-memory write
//   hitCount_o/missCount_o  performance counters (optional)
// -----------------------------------------------------------------------------
module fetch_tag_check #(
    parameter int offsetSize = 5,
    parameter int indexSize  = 8,
    parameter int tagSize    = 64 - (offsetSize + indexSize)
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  flushPipeline_i,
    input  logic                  fetchUnitStall_i,
    input  logic                  enable_i,
    input  logic [tagSize-1:0]    tag_i,
    input  logic [tagSize:0]      queriedTag_i,
    input  logic [indexSize-1:0]  index_i,
    input  logic [offsetSize-1:0] offset_i,
    output logic                  hit_o,
    output logic [indexSize-1:0]  index_o,
    output logic [offsetSize-1:0] offset_o,
    output logic                  stall_o,
    output logic                  missReq_o,
    output logic [63:0]           missAddr_o,
    input  logic                  missAck_i,
    input  logic                  fillDone_i,
    output logic [tagSize-1:0]    newTag_o,
    output logic [indexSize-1:0]  newIndex_o,
    output logic                  updateEnable_o
`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
    ,
    output logic [31:0]           hitCount_o,
    output logic [31:0]           missCount_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_FILL,
        UPDATE,
        REPLAY
    } state_t;

    state_t                  state_q, state_d;
    logic [tagSize-1:0]      cap_tag_q;
    logic [indexSize-1:0]    cap_index_q;
    logic [offsetSize-1:0]   cap_offset_q;
    logic                    flushed_q;   // flush seen after the fill was acked
    logic                    hit_q;
    logic [indexSize-1:0]    index_q;
    logic [offsetSize-1:0]   offset_q;

    logic is_hit;
    logic idle_accept;
    logic capture;
    logic replay_load;

    assign is_hit = enable_i && queriedTag_i[0] && (queriedTag_i[tagSize:1] == tag_i);

    // A query is taken only in IDLE with the downstream free and no flush.
    // A flushed query belongs to the squashed instruction stream.
    assign idle_accept = (state_q == IDLE) && !fetchUnitStall_i && !flushPipeline_i && enable_i;
    assign capture     = idle_accept && !is_hit;

    // The replay hit is presented on entry to REPLAY even under a downstream
    // stall; the stall then keeps it on the outputs until it is consumed.
    assign replay_load = (state_q == UPDATE) && !flushed_q && !flushPipeline_i;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: state_d gets a default before the case so that no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (capture) state_d = REQ;
            // An ack in the same cycle as a flush means the fill is already
            // committed, so it must be followed through to the tag write.
            REQ:       if (missAck_i) state_d = WAIT_FILL;
                       else if (flushPipeline_i) state_d = IDLE;
            // fillDone_i is only looked at from here on.
            WAIT_FILL: if (fillDone_i) state_d = UPDATE;
            UPDATE:    state_d = (flushed_q || flushPipeline_i) ? IDLE : REPLAY;
            REPLAY:    if (flushPipeline_i || !fetchUnitStall_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State register and captured miss fields
    // ---------------------------------------------------------------------
    // NOTE: every register, including the captured miss fields, is reset.
    // This keeps the outputs at zero under reset and makes the first miss
    // address deterministic in simulation.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // that every flop samples the pre-edge values of the others.
            state_q      <= IDLE;
            cap_tag_q    <= '0;
            cap_index_q  <= '0;
            cap_offset_q <= '0;
            flushed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cap_tag_q    <= tag_i;
                cap_index_q  <= index_i;
                cap_offset_q <= offset_i;
                flushed_q    <= 1'b0;
            end else if (flushPipeline_i &&
                         ((state_q == WAIT_FILL) || ((state_q == REQ) && missAck_i))) begin
                flushed_q <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Hit output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            hit_q    <= 1'b0;
            index_q  <= '0;
            offset_q <= '0;
        end else if (flushPipeline_i) begin
            hit_q    <= 1'b0;
            index_q  <= '0;
            offset_q <= '0;
        end else if (replay_load) begin
            hit_q    <= 1'b1;
            index_q  <= cap_index_q;
            offset_q <= cap_offset_q;
        end else if (fetchUnitStall_i) begin
            hit_q    <= hit_q;
        end else if (state_q == IDLE) begin
            hit_q <= is_hit;
            if (is_hit) begin
                index_q  <= index_i;
                offset_q <= offset_i;
            end
        end else begin
            // Busy with a miss, or leaving REPLAY after the replay was consumed.
            hit_q <= 1'b0;
        end
    end

    assign hit_o    = hit_q;
    assign index_o  = index_q;
    assign offset_o = offset_q;

    // ---------------------------------------------------------------------
    // Miss request and tag write, decoded from the state register
    // ---------------------------------------------------------------------
    assign stall_o        = (state_q != IDLE);
    assign missReq_o      = (state_q == REQ);
    assign missAddr_o     = missReq_o ? 64'({cap_tag_q, cap_index_q, {offsetSize{1'b0}}}) : '0;
    assign updateEnable_o = (state_q == UPDATE);
    assign newTag_o       = updateEnable_o ? cap_tag_q : '0;
    assign newIndex_o     = updateEnable_o ? cap_index_q : '0;

`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
    // ---------------------------------------------------------------------
    // Performance counters. Both wrap naturally, and flush does not clear them.
    // ---------------------------------------------------------------------
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (idle_accept && is_hit) hit_count_q <= hit_count_q + 32'd1;
            if (capture)               miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hitCount_o  = hit_count_q;
    assign missCount_o = miss_count_q;
`endif

endmodule

// File: tb/tb_fetch_tag_check.sv
// -----------------------------------------------------------------------------
// tb_fetch_tag_check
//
// Purpose:
//   Self-checking bench for fetch_tag_check. A behavioural model tracks the
//   outstanding miss as a set of progress flags (acked, filled, written,
//   cancelled). A negedge compare process checks every DUT output against
//   that model on each cycle. Directed sequences pin the model with
//   hand-computed values, and a randomized phase then exercises the
//   interactions.
// -----------------------------------------------------------------------------
module tb_fetch_tag_check;

    localparam int OFF_W = 5;
    localparam int IDX_W = 8;
    localparam int TAG_W = 64 - (OFF_W + IDX_W);

    logic             clock_i = 1'b0;
    logic             reset_i = 1'b0;
    logic             flushPipeline_i = 1'b0;
    logic             fetchUnitStall_i = 1'b0;
    logic             enable_i = 1'b0;
    logic [TAG_W-1:0] tag_i = '0;
    logic [TAG_W:0]   queriedTag_i = '0;
    logic [IDX_W-1:0] index_i = '0;
    logic [OFF_W-1:0] offset_i = '0;
    logic             missAck_i = 1'b0;
    logic             fillDone_i = 1'b0;
    logic             hit_o;
    logic [IDX_W-1:0] index_o;
    logic [OFF_W-1:0] offset_o;
    logic             stall_o;
    logic             missReq_o;
    logic [63:0]      missAddr_o;
    logic [TAG_W-1:0] newTag_o;
    logic [IDX_W-1:0] newIndex_o;
    logic             updateEnable_o;
`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
    logic [31:0]      hitCount_o;
    logic [31:0]      missCount_o;
`endif

    fetch_tag_check #(
        .offsetSize(OFF_W),
        .indexSize (IDX_W)
    ) dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .flushPipeline_i (flushPipeline_i),
        .fetchUnitStall_i(fetchUnitStall_i),
        .enable_i        (enable_i),
        .tag_i           (tag_i),
        .queriedTag_i    (queriedTag_i),
        .index_i         (index_i),
        .offset_i        (offset_i),
        .hit_o           (hit_o),
        .index_o         (index_o),
        .offset_o        (offset_o),
        .stall_o         (stall_o),
        .missReq_o       (missReq_o),
        .missAddr_o      (missAddr_o),
        .missAck_i       (missAck_i),
        .fillDone_i      (fillDone_i),
        .newTag_o        (newTag_o),
        .newIndex_o      (newIndex_o),
        .updateEnable_o  (updateEnable_o)
`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
        ,
        .hitCount_o      (hitCount_o),
        .missCount_o     (missCount_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Behavioural model
    // ---------------------------------------------------------------------
    bit               m_busy, m_acked, m_filled, m_written, m_cancel;
    logic [TAG_W-1:0] m_tag;
    logic [IDX_W-1:0] m_index;
    logic [OFF_W-1:0] m_offset;
    logic             e_hit;
    logic [IDX_W-1:0] e_index;
    logic [OFF_W-1:0] e_offset;
    logic [31:0]      e_hits, e_misses;

    task automatic model_reset();
        {m_busy, m_acked, m_filled, m_written, m_cancel} = '0;
        m_tag = '0; m_index = '0; m_offset = '0;
        e_hit = 1'b0; e_index = '0; e_offset = '0;
        e_hits = '0; e_misses = '0;
    endtask

    task automatic model_step();
        bit hit_now, idle, replay_entry;
        hit_now = enable_i && queriedTag_i[0] && (queriedTag_i[TAG_W:1] == tag_i);
        idle    = !m_busy;
        // Replay is presented right after the tag write unless flushed.
        replay_entry = m_busy && m_filled && !m_written && !m_cancel && !flushPipeline_i;

        if (flushPipeline_i) begin
            e_hit = 1'b0; e_index = '0; e_offset = '0;
        end else if (replay_entry) begin
            e_hit = 1'b1; e_index = m_index; e_offset = m_offset;
        end else if (fetchUnitStall_i) begin
            e_hit = e_hit;
        end else if (idle) begin
            e_hit = hit_now;
            if (hit_now) begin
                e_index = index_i; e_offset = offset_i; e_hits++;
            end
        end else begin
            e_hit = 1'b0;
        end

        if (idle) begin
            if (!fetchUnitStall_i && !flushPipeline_i && enable_i && !hit_now) begin
                m_busy = 1'b1;
                {m_acked, m_filled, m_written, m_cancel} = '0;
                m_tag = tag_i; m_index = index_i; m_offset = offset_i;
                e_misses++;
            end
        end else if (!m_acked) begin
            if (missAck_i) begin
                m_acked = 1'b1;
                if (flushPipeline_i) m_cancel = 1'b1;
            end else if (flushPipeline_i) begin
                m_busy = 1'b0;
            end
        end else if (!m_filled) begin
            if (flushPipeline_i) m_cancel = 1'b1;
            if (fillDone_i)      m_filled = 1'b1;
        end else if (!m_written) begin
            m_written = 1'b1;
            if (m_cancel || flushPipeline_i) m_busy = 1'b0;
        end else if (flushPipeline_i || !fetchUnitStall_i) begin
            m_busy = 1'b0;
        end
    endtask

    always @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) model_reset();
        else          model_step();
    end

    // ---------------------------------------------------------------------
    // Per-cycle compare against the model
    // ---------------------------------------------------------------------
    always @(negedge clock_i) begin
        if (check_en) begin
            logic e_req, e_upd;
            e_req = m_busy && !m_acked;
            e_upd = m_busy && m_filled && !m_written;
            check("hit_o",          64'(hit_o),          64'(e_hit));
            check("index_o",        64'(index_o),        64'(e_index));
            check("offset_o",       64'(offset_o),       64'(e_offset));
            check("stall_o",        64'(stall_o),        64'(m_busy));
            check("missReq_o",      64'(missReq_o),      64'(e_req));
            check("missAddr_o",     missAddr_o,          e_req ? {m_tag, m_index, 5'b0} : 64'd0);
            check("updateEnable_o", 64'(updateEnable_o), 64'(e_upd));
            check("newTag_o",       64'(newTag_o),       e_upd ? 64'(m_tag) : 64'd0);
            check("newIndex_o",     64'(newIndex_o),     e_upd ? 64'(m_index) : 64'd0);
`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
            check("hitCount_o",     64'(hitCount_o),     64'(e_hits));
            check("missCount_o",    64'(missCount_o),    64'(e_misses));
`endif
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick();
        @(negedge clock_i);
    endtask

    task automatic quiet();
        enable_i = 1'b0; flushPipeline_i = 1'b0; fetchUnitStall_i = 1'b0;
        missAck_i = 1'b0; fillDone_i = 1'b0;
    endtask

    task automatic query(input logic [TAG_W-1:0] t, input logic valid,
                         input logic [TAG_W-1:0] stored, input logic [IDX_W-1:0] idx,
                         input logic [OFF_W-1:0] off);
        enable_i = 1'b1; tag_i = t; queriedTag_i = {stored, valid};
        index_i = idx; offset_i = off;
    endtask

    // Takes a miss from REQ through the fill and write, leaving the FSM in REPLAY.
    task automatic complete_fill();
        missAck_i = 1'b1; tick(); missAck_i = 1'b0;
        fillDone_i = 1'b1; tick(); fillDone_i = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        quiet();
        reset_i = 1'b0;
        repeat (2) tick();
        reset_i = 1'b1;
        tick();
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        check_en = 1'b1;
        repeat (2) tick();
        check("reset hit_o",     64'(hit_o),     64'd0);
        check("reset stall_o",   64'(stall_o),   64'd0);
        check("reset missAddr",  missAddr_o,     64'd0);
        check("reset index_o",   64'(index_o),   64'd0);
        reset_i = 1'b1;
        tick();

        // Plain hit.
        query(TAG_W'(5), 1'b1, TAG_W'(5), 8'h12, 5'h04);
        tick();
        enable_i = 1'b0;
        check("hit case hit_o",    64'(hit_o),    64'd1);
        check("hit case index_o",  64'(index_o),  64'h12);
        check("hit case offset_o", 64'(offset_o), 64'h04);
        check("hit case stall_o",  64'(stall_o),  64'd0);
        tick();
        check("hit one cycle", 64'(hit_o), 64'd0);

        // Miss on a clear valid bit, fill arriving three cycles after the ack.
        query(TAG_W'(5), 1'b0, TAG_W'(5), 8'h12, 5'h00);
        tick();
        enable_i = 1'b0;
        check("miss missReq_o",  64'(missReq_o), 64'd1);
        check("miss missAddr_o", missAddr_o,     64'h0000_0000_0000_A240);
        check("miss stall_o",    64'(stall_o),   64'd1);
        tick();
        check("miss req held",   64'(missReq_o), 64'd1);
        missAck_i = 1'b1; tick(); missAck_i = 1'b0;
        check("wait missReq_o",  64'(missReq_o), 64'd0);
        repeat (2) tick();
        check("wait stall_o",    64'(stall_o),   64'd1);
        fillDone_i = 1'b1; tick(); fillDone_i = 1'b0;
        check("update strobe",   64'(updateEnable_o), 64'd1);
        check("update newTag",   64'(newTag_o),       64'h5);
        check("update newIndex", 64'(newIndex_o),     64'h12);
        check("update stall_o",  64'(stall_o),        64'd1);
        tick();
        check("replay hit_o",    64'(hit_o),          64'd1);
        check("replay index_o",  64'(index_o),        64'h12);
        check("replay stall_o",  64'(stall_o),        64'd1);
        check("replay no write", 64'(updateEnable_o), 64'd0);
        tick();
        check("after replay hit",   64'(hit_o),   64'd0);
        check("after replay stall", 64'(stall_o), 64'd0);

        // Flush while waiting for the fill: write still happens, no replay.
        query(TAG_W'(9), 1'b1, TAG_W'(3), 8'h40, 5'h08);
        tick(); enable_i = 1'b0;
        missAck_i = 1'b1; tick(); missAck_i = 1'b0;
        flushPipeline_i = 1'b1; tick(); flushPipeline_i = 1'b0;
        fillDone_i = 1'b1; tick(); fillDone_i = 1'b0;
        check("flush wait update",  64'(updateEnable_o), 64'd1);
        check("flush wait newTag",  64'(newTag_o),       64'h9);
        tick();
        check("flush wait no hit",  64'(hit_o),   64'd0);
        check("flush wait idle",    64'(stall_o), 64'd0);

        // Ack and fill together in REQ: only the ack is taken.
        query(TAG_W'(2), 1'b1, TAG_W'(1), 8'h07, 5'h01);
        tick(); enable_i = 1'b0;
        missAck_i = 1'b1; fillDone_i = 1'b1; tick();
        missAck_i = 1'b0; fillDone_i = 1'b0;
        check("ack+fill no write", 64'(updateEnable_o), 64'd0);
        tick();
        check("ack+fill still waiting", 64'(updateEnable_o), 64'd0);
        check("ack+fill stall",         64'(stall_o),        64'd1);
        fillDone_i = 1'b1; tick(); fillDone_i = 1'b0;
        check("ack+fill late write", 64'(updateEnable_o), 64'd1);
        repeat (2) tick();

        // Reset mid-miss.
        query(TAG_W'(6), 1'b1, TAG_W'(4), 8'h33, 5'h02);
        tick(); enable_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        check("reset mid-miss missReq", 64'(missReq_o), 64'd0);
        check("reset mid-miss stall",   64'(stall_o),   64'd0);
        missAck_i = 1'b1; fillDone_i = 1'b1;
        tick(); tick();
        quiet();
        reset_i = 1'b1;
        repeat (3) tick();
        check("reset mid-miss no write", 64'(updateEnable_o), 64'd0);

        // Downstream stall during REPLAY for four cycles.
        query(TAG_W'(7), 1'b1, TAG_W'(0), 8'hA5, 5'h1F);
        tick(); enable_i = 1'b0;
        missAck_i = 1'b1; tick(); missAck_i = 1'b0;
        fillDone_i = 1'b1; tick(); fillDone_i = 1'b0;
        fetchUnitStall_i = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("replay stall hit_o",   64'(hit_o),   64'd1);
            check("replay stall index_o", 64'(index_o), 64'hA5);
            tick();
        end
        fetchUnitStall_i = 1'b0;
        check("replay consumed once", 64'(hit_o & ~fetchUnitStall_i), 64'd1);
        tick();
        check("replay released", 64'(hit_o),   64'd0);
        check("replay to idle",  64'(stall_o), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            enable_i         = ($urandom_range(0, 99) < 60);
            tag_i            = TAG_W'($urandom_range(0, 3));
            queriedTag_i     = {TAG_W'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0)};
            index_i          = IDX_W'($urandom);
            offset_i         = OFF_W'($urandom);
            flushPipeline_i  = ($urandom_range(0, 99) < 4);
            fetchUnitStall_i = ($urandom_range(0, 99) < 20);
            missAck_i        = ($urandom_range(0, 99) < 30);
            fillDone_i       = ($urandom_range(0, 99) < 30);
            tick();
        end
        quiet();
        missAck_i = 1'b1; fillDone_i = 1'b1;
        repeat (8) tick();
        quiet();
        tick();
        check("drain idle", 64'(stall_o), 64'd0);

`ifdef FETCH_TAG_CHECK_PERF_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            query(TAG_W'(i), 1'b1, TAG_W'(i), IDX_W'(i), OFF_W'(i));
            tick(); enable_i = 1'b0; tick();
        end
        for (int i = 0; i < 2; i++) begin
            query(TAG_W'(8), 1'b1, TAG_W'(9), IDX_W'(i), OFF_W'(0));
            tick(); enable_i = 1'b0;
            complete_fill();
            tick();
        end
        check("perf hits",   64'(hitCount_o),  64'd3);
        check("perf misses", 64'(missCount_o), 64'd2);
        #2;
        dut.hit_count_q = 32'hFFFF_FFFF;
        e_hits          = 32'hFFFF_FFFF;
        tick();
        query(TAG_W'(1), 1'b1, TAG_W'(1), 8'h01, 5'h01);
        tick(); enable_i = 1'b0;
        check("perf hit wrap", 64'(hitCount_o), 64'd0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
